// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over a
// queued long-latency result stream; also tracks pending destinations for RAW detection.
module wb_arbiter #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wb_we,
    input  logic [4:0]   wb_wa,
    input  logic [N-1:0] wb_wd,
    input  logic         lu_valid,
    output logic         lu_ready,
    input  logic [4:0]   lu_wa,
    input  logic [N-1:0] lu_wd,
    input  logic         iss_valid,
    input  logic [4:0]   iss_wa,
    output logic         we3,
    output logic [4:0]   wa3,
    output logic [N-1:0] wd3,
    input  logic [4:0]   qa1,
    input  logic [4:0]   qa2,
    output logic         hz1,
    output logic         hz2,
    output logic         busy,
    output logic         sb_err
);

    localparam int unsigned AW = 5;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] fifo_wa [DEPTH];
    logic [N-1:0]  fifo_wd [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [31:0]   pend, pend_nxt, pend_set, pend_clr;
    logic          ready_q;

    logic          wb_sel, hs, pop, bypass, push, ld_lu, err_nxt;
    logic [AW-1:0] ld_wa;
    logic [N-1:0]  ld_wd;

    // Slot selection, FIFO bookkeeping and scoreboard next-state.
    always_comb begin
        wb_sel    = 1'b0;
        hs        = 1'b0;
        pop       = 1'b0;
        bypass    = 1'b0;
        push      = 1'b0;
        ld_lu     = 1'b0;
        ld_wa     = lu_wa;
        ld_wd     = lu_wd;
        count_nxt = count;
        pend_set  = '0;
        pend_clr  = '0;
        pend_nxt  = pend;
        err_nxt   = sb_err;

        wb_sel = wb_we && (wb_wa != '0);
        hs     = lu_valid && ready_q;
        pop    = !wb_sel && (count != '0);
        bypass = !wb_sel && (count == '0) && hs;
        push   = hs && !bypass;
        ld_lu  = pop || bypass;
        if (pop) begin
            ld_wa = fifo_wa[rd_ptr];
            ld_wd = fifo_wd[rd_ptr];
        end
        count_nxt = count + CW'(push) - CW'(pop);

        if (iss_valid && (iss_wa != '0))
            pend_set = 32'(1) << iss_wa;
        if (ld_lu && (ld_wa != '0))
            pend_clr = 32'(1) << ld_wa;
        pend_nxt = ((pend & ~pend_clr) | pend_set) & ~32'(1);

        if ((iss_valid && (iss_wa != '0) && pend[iss_wa]) || (wb_sel && pend[wb_wa]))
            err_nxt = 1'b1;
    end

    // Control state and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pend    <= '0;
            ready_q <= 1'b0;
            sb_err  <= 1'b0;
            we3     <= 1'b0;
            wa3     <= '0;
            wd3     <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            count   <= count_nxt;
            pend    <= pend_nxt;
            ready_q <= (count_nxt < CW'(DEPTH));
            sb_err  <= err_nxt;
            if (wb_sel) begin
                we3 <= 1'b1;
                wa3 <= wb_wa;
                wd3 <= wb_wd;
            end else if (ld_lu) begin
                we3 <= (ld_wa != '0);
                wa3 <= ld_wa;
                wd3 <= ld_wd;
            end else begin
                we3 <= 1'b0;
            end
        end
    end

    // Queue storage carries data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wa[wr_ptr] <= lu_wa;
            fifo_wd[wr_ptr] <= lu_wd;
        end
    end

    assign lu_ready = ready_q;
    assign hz1      = (qa1 != '0) && (pend[qa1] || (we3 && (wa3 == qa1)));
    assign hz2      = (qa2 != '0) && (pend[qa2] || (we3 && (wa3 == qa2)));
    assign busy     = (|pend) || (count != '0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter: cycle table plus reset/scoreboard sequences.
module tb_wb_arbiter;

    localparam int unsigned N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wb_we, lu_valid, lu_ready, iss_valid;
    logic [4:0]   wb_wa, lu_wa, iss_wa, qa1, qa2, wa3;
    logic [N-1:0] wb_wd, lu_wd, wd3;
    logic         we3, hz1, hz2, busy, sb_err;

    int n_vec = 0;
    int n_bad = 0;

    wb_arbiter #(.N(N), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wa(lu_wa), .lu_wd(lu_wd),
        .iss_valid(iss_valid), .iss_wa(iss_wa),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .qa1(qa1), .qa2(qa2), .hz1(hz1), .hz2(hz2),
        .busy(busy), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wbwe;  logic [4:0] wbwa; logic [31:0] wbwd;
        logic        luv;   logic [4:0] luwa; logic [31:0] luwd;
        logic        iv;    logic [4:0] iwa;
        logic [4:0]  q1;    logic [4:0] q2;
        logic        e_we;  logic [4:0] e_wa; logic [31:0] e_wd; logic ck_ad;
        logic        e_rdy; logic e_hz1; logic e_hz2; logic e_busy; logic e_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic wbwe, input logic [4:0] wbwa, input logic [31:0] wbwd,
        input logic luv, input logic [4:0] luwa, input logic [31:0] luwd,
        input logic iv, input logic [4:0] iwa, input logic [4:0] q1, input logic [4:0] q2,
        input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd, input logic ck_ad,
        input logic e_rdy, input logic e_hz1, input logic e_hz2, input logic e_busy,
        input logic e_err);
        vec_t v;
        v.wbwe = wbwe; v.wbwa = wbwa; v.wbwd = wbwd;
        v.luv = luv; v.luwa = luwa; v.luwd = luwd;
        v.iv = iv; v.iwa = iwa; v.q1 = q1; v.q2 = q2;
        v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.ck_ad = ck_ad;
        v.e_rdy = e_rdy; v.e_hz1 = e_hz1; v.e_hz2 = e_hz2; v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive(input logic wbwe, input logic [4:0] wbwa, input logic [31:0] wbwd,
                         input logic luv, input logic [4:0] luwa, input logic [31:0] luwd,
                         input logic iv, input logic [4:0] iwa,
                         input logic [4:0] q1, input logic [4:0] q2);
        wb_we = wbwe; wb_wa = wbwa; wb_wd = wbwd;
        lu_valid = luv; lu_wa = luwa; lu_wd = luwd;
        iss_valid = iv; iss_wa = iwa; qa1 = q1; qa2 = q2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [42:0] act, exp, mask;

        // wbwe wbwa wbwd      luv luwa luwd     iv iwa q1 q2 | we wa wd ck  rdy hz1 hz2 busy err
        vq.push_back(mk(0, 0, 0,          0, 0,  0,          0, 0, 0, 0,  0, 0,  0,          1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,          0, 0,  0,          1, 5, 5, 0,  0, 0,  0,          1, 1, 1, 0, 1, 0));
        vq.push_back(mk(0, 0, 0,          1, 5,  32'h1234,   0, 0, 5, 0,  1, 5,  32'h1234,   1, 1, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,          0, 0,  0,          0, 0, 5, 0,  0, 5,  32'h1234,   1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,          0, 0,  0,          1, 9, 9, 0,  0, 5,  32'h1234,   1, 1, 1, 0, 1, 0));
        vq.push_back(mk(0, 0, 0,          0, 0,  0,          0, 0, 9, 0,  0, 5,  32'h1234,   1, 1, 1, 0, 1, 0));
        vq.push_back(mk(0, 0, 0,          1, 9,  32'h99,     0, 0, 9, 0,  1, 9,  32'h99,     1, 1, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,          0, 0,  0,          0, 0, 9, 0,  0, 9,  32'h99,     1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,          0, 0,  0,          1, 7, 7, 8,  0, 9,  32'h99,     1, 1, 1, 0, 1, 0));
        vq.push_back(mk(0, 0, 0,          0, 0,  0,          1, 8, 7, 8,  0, 9,  32'h99,     1, 1, 1, 1, 1, 0));
        vq.push_back(mk(1, 3, 32'h30,     1, 7,  32'h70,     0, 0, 7, 8,  1, 3,  32'h30,     1, 1, 1, 1, 1, 0));
        vq.push_back(mk(1, 3, 32'h31,     1, 8,  32'h80,     0, 0, 7, 8,  1, 3,  32'h31,     1, 0, 1, 1, 1, 0));
        vq.push_back(mk(1, 3, 32'h32,     1, 10, 32'hA0,     0, 0, 7, 8,  1, 3,  32'h32,     1, 0, 1, 1, 1, 0));
        vq.push_back(mk(1, 3, 32'h33,     1, 10, 32'hA0,     0, 0, 7, 8,  1, 3,  32'h33,     1, 0, 1, 1, 1, 0));
        vq.push_back(mk(0, 0, 0,          1, 10, 32'hA0,     0, 0, 7, 8,  1, 7,  32'h70,     1, 1, 1, 1, 1, 0));
        vq.push_back(mk(0, 0, 0,          1, 10, 32'hA0,     0, 0, 7, 8,  1, 8,  32'h80,     1, 1, 0, 1, 1, 0));
        vq.push_back(mk(0, 0, 0,          0, 0,  0,          0, 0, 7, 8,  1, 10, 32'hA0,     1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,          0, 0,  0,          0, 0, 7, 8,  0, 10, 32'hA0,     1, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 32'hDEAD,   1, 4,  32'h44,     0, 0, 0, 4,  1, 4,  32'h44,     1, 1, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0,          1, 0,  32'h55,     0, 0, 0, 0,  0, 0,  0,          0, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,          0, 0,  0,          0, 0, 0, 0,  0, 0,  0,          0, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 2, 32'h22,     0, 0,  0,          1, 6, 6, 0,  1, 2,  32'h22,     1, 1, 1, 0, 1, 0));
        vq.push_back(mk(0, 0, 0,          0, 0,  0,          1, 6, 6, 0,  0, 2,  32'h22,     1, 1, 1, 0, 1, 1));
        vq.push_back(mk(0, 0, 0,          1, 6,  32'h66,     0, 0, 6, 0,  1, 6,  32'h66,     1, 1, 1, 0, 0, 1));
        vq.push_back(mk(0, 0, 0,          0, 0,  0,          0, 0, 6, 0,  0, 6,  32'h66,     1, 1, 0, 0, 0, 1));

        do_reset_start: begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("rst_init", {60'd0, we3, lu_ready, busy, sb_err}, 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
        end

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].wbwe, vq[i].wbwa, vq[i].wbwd, vq[i].luv, vq[i].luwa, vq[i].luwd,
                  vq[i].iv, vq[i].iwa, vq[i].q1, vq[i].q2);
            step();
            act  = {we3, wa3, wd3, lu_ready, hz1, hz2, busy, sb_err};
            exp  = {vq[i].e_we, vq[i].e_wa, vq[i].e_wd, vq[i].e_rdy,
                    vq[i].e_hz1, vq[i].e_hz2, vq[i].e_busy, vq[i].e_err};
            mask = {1'b1, {37{vq[i].ck_ad}}, 5'b11111};
            check($sformatf("vec%0d", i), 64'(act & mask), 64'(exp & mask));
        end

        // Two results queued behind pipeline writes, then asynchronous reset.
        drive(1, 3, 32'h1, 1, 7, 32'h77, 0, 0, 0, 0);
        step();
        drive(1, 3, 32'h2, 1, 8, 32'h88, 0, 0, 0, 0);
        step();
        check("fifo_full", {62'd0, lu_ready, busy}, 64'b01);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {we3, wa3, wd3, lu_ready, busy, sb_err}, 64'd0);
        step();
        check("rst_hold", {62'd0, lu_ready, we3}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_release", {61'd0, lu_ready, we3, busy}, 64'b100);
        step();
        check("rst_discard", {61'd0, lu_ready, we3, busy}, 64'b100);

        // Simultaneous set and clear of one register: set wins.
        drive(0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
        step();
        drive(0, 0, 0, 1, 12, 32'hC0, 1, 12, 12, 0);
        step();
        check("setclr_write", {27'd0, we3, wa3, wd3}, {27'd0, 1'b1, 5'd12, 32'hC0});
        drive(0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
        step();
        check("setclr_pend", {61'd0, hz1, busy, sb_err}, 64'b111);

        // Pipeline write to a pending register flags WAW but still writes.
        do_reset();
        check("err_cleared", {62'd0, sb_err, busy}, 64'd0);
        drive(0, 0, 0, 0, 0, 0, 1, 11, 0, 11);
        step();
        drive(1, 11, 32'h5, 0, 0, 0, 0, 0, 0, 11);
        step();
        check("wb_waw", {24'd0, we3, wa3, wd3, hz2, busy, sb_err},
              {24'd0, 1'b1, 5'd11, 32'h5, 3'b111});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
